// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Decouples ALU results from register writeback with a 2-entry FIFO of
// {y, cout, zout, dst}, and keeps the architectural carry/zero flags.
// Flags update on the push edge (not at writeback), so the next ALU op
// sees the new carry through carry_flag immediately.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid / in_ready   upstream ALU result handshake (in_ready = count < 2)
//   in_y, in_cout, in_zout, in_flag_we, in_dst   ALU result fields
//   flush                 discard every buffered result (flags untouched)
//   out_valid / out_ready writeback handshake on the head entry
//   out_data, out_dst, out_carry, out_zero       head entry, zero when empty
//   carry_flag, zero_flag architectural flags (carry feeds ALU fcin)
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_y,
    input  logic          in_cout,
    input  logic          in_zout,
    input  logic          in_flag_we,
    input  logic [RW-1:0] in_dst,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [RW-1:0] out_dst,
    output logic          out_carry,
    output logic          out_zero,
    output logic          carry_flag,
    output logic          zero_flag
);

    // Storage
    logic [DW-1:0] r_y   [2];
    logic [RW-1:0] r_dst [2];
    logic [1:0]    r_c;
    logic [1:0]    r_z;

    logic [1:0]    r_count;
    logic          r_wptr;
    logic          r_rptr;
    logic          r_carry;
    logic          r_zero;

    // Next-state
    logic [1:0]    w_count_d;
    logic          w_wptr_d;
    logic          w_rptr_d;
    logic          w_push;
    logic          w_pop;
    logic          w_not_empty;

    assign w_not_empty = (r_count != 2'd0);

    // Handshake qualifiers. flush suppresses both, so nothing moves while
    // the buffer is being discarded.
    always_comb begin
        w_push = in_valid && (r_count < 2'd2) && !flush;
        w_pop  = w_not_empty && out_ready && !flush;
    end

    always_comb begin
        w_count_d = r_count;
        w_wptr_d  = r_wptr;
        w_rptr_d  = r_rptr;
        if (flush) begin
            w_count_d = 2'd0;
            w_wptr_d  = 1'b0;
            w_rptr_d  = 1'b0;
        end else begin
            // 1-bit pointers wrap 1 -> 0 naturally.
            if (w_push) begin
                w_wptr_d = r_wptr + 1'b1;
            end
            if (w_pop) begin
                w_rptr_d = r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   w_count_d = r_count + 2'd1;
                2'b01:   w_count_d = r_count - 2'd1;
                default: w_count_d = r_count;
            endcase
        end
    end

    // Control state and flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_wptr  <= w_wptr_d;
            r_rptr  <= w_rptr_d;
            if (w_push && in_flag_we) begin
                r_carry <= in_cout;
                r_zero  <= in_zout;
            end
        end
    end

    // Entry storage: only the slot being written changes, so the head is
    // stable under backpressure.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_y[i]   <= '0;
                r_dst[i] <= '0;
            end
            r_c <= 2'b00;
            r_z <= 2'b00;
        end else if (w_push) begin
            r_y[r_wptr]   <= in_y;
            r_dst[r_wptr] <= in_dst;
            r_c[r_wptr]   <= in_cout;
            r_z[r_wptr]   <= in_zout;
        end
    end

    // Outputs: head entry is masked to zero when the FIFO is empty.
    always_comb begin
        in_ready   = (r_count < 2'd2);
        out_valid  = w_not_empty;
        out_data   = '0;
        out_dst    = '0;
        out_carry  = 1'b0;
        out_zero   = 1'b0;
        if (w_not_empty) begin
            out_data  = r_y[r_rptr];
            out_dst   = r_dst[r_rptr];
            out_carry = r_c[r_rptr];
            out_zero  = r_z[r_rptr];
        end
        carry_flag = r_carry;
        zero_flag  = r_zero;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: DW, 16, result data width (equals ALU y width).
REQ-002 Parameter: RW, 3, destination register index width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 in_valid  input  1  upstream ALU result valid this cycle.
REQ-007 in_ready  output  1  stage can accept a result this cycle.
REQ-008 in_y  input  DW  ALU result (yout).
REQ-009 in_cout  input  1  ALU carry out.
REQ-010 in_zout  input  1  ALU zero out.
REQ-011 in_flag_we  input  1  result updates architectural carry/zero flags.
REQ-012 in_dst  input  RW  writeback register index.
REQ-013 flush  input  1  discard all buffered results.
REQ-014 out_valid  output  1  head entry available to writeback.
REQ-015 out_ready  input  1  writeback consumes head this cycle.
REQ-016 out_data  output  DW  head entry result.
REQ-017 out_dst  output  RW  head entry register index.
REQ-018 out_carry  output  1  head entry carry snapshot.
REQ-019 out_zero  output  1  head entry zero snapshot.
REQ-020 carry_flag  output  1  architectural carry; wired to ALU fcin.
REQ-021 zero_flag  output  1  architectural zero flag.

Function
REQ-022 Storage SHALL be a 2-entry FIFO of {y, cout, zout, dst}, with 2-bit occupancy count 0..2.
REQ-023 Push SHALL occur when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-024 in_ready SHALL be combinational: 1 iff count < 2; independent of out_ready (no pass-through at full).
REQ-025 out_valid SHALL equal (count != 0); out_* SHALL show oldest entry, all zero when count == 0.
REQ-026 Latency: result pushed in cycle N SHALL appear on out_* in cycle N+1 when FIFO was empty.
REQ-027 Simultaneous push and pop at count 1 SHALL keep count 1, with new entry as head next cycle.
REQ-028 Push at count 0 with out_ready high SHALL NOT bypass; entry appears next cycle.
REQ-029 Pop at count 0 SHALL be a no-op; push at count 2 SHALL be impossible (in_ready low) and in_valid ignored.
REQ-030 Read/write pointers SHALL be 1-bit, wrapping 1 -> 0.
REQ-031 On push with in_flag_we=1, carry_flag <= in_cout and zero_flag <= in_zout on the same edge, so the next ALU op sees the new carry without waiting for writeback.
REQ-032 On push with in_flag_we=0, or no push, flags SHALL hold.
REQ-033 flush SHALL set count and both pointers to 0 next cycle, leave flags unchanged, and override any same-cycle push or pop.
REQ-034 Entry contents SHALL hold while out_valid && !out_ready (stable under backpressure).

Reset
REQ-035 While reset_n=0 at a rising edge: count=0, pointers=0, carry_flag=0, zero_flag=0, all entries cleared.
REQ-036 Reset SHALL override flush, push and pop; in-flight data lost; out_valid=0, out_*=0 and in_ready=1 from the first cycle after reset.

Verification
REQ-037 Single op: in_y=0x1234, cout=1, zout=0, flag_we=1, dst=5, out_ready=1 -> next cycle out_valid=1, out_data=0x1234, out_dst=5, carry_flag=1.
REQ-038 Backpressure: out_ready=0, push 0xAAAA then 0x5555 -> in_ready=0 after second push; third in_valid ignored; then out_ready=1 -> 0xAAAA then 0x5555 in order, in_ready returns 1.
REQ-039 Flag enable: push cout=1 flag_we=1, then push cout=0, zout=1, flag_we=0 -> carry_flag stays 1, zero_flag stays 0.
REQ-040 Streaming: in_valid and out_ready held high for 8 cycles with y=0..7 -> out_data 0..7 on consecutive cycles, count never exceeds 1.
REQ-041 Flush with full FIFO and same-cycle in_valid -> next cycle out_valid=0, count=0, flags unchanged, flushed and same-cycle inputs never emitted.
REQ-042 Reset mid-operation: count=2, carry_flag=1, reset_n=0 for one edge -> out_valid=0, carry_flag=0, in_ready=1.
